// File: rtl/etapa_salida.sv
// Output stage of the pipelined divider: applies sign correction to the final
// quotient/remainder and holds results in a 2-entry in-order buffer.
module etapa_salida #(
  parameter int AnchoDv = 15,
  parameter int AnchoDd = 31,
  parameter int AnchoQ  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             goIn,
  input  logic [AnchoDv:0] divisorIn,
  input  logic [AnchoDd:0] dividendIn,
  input  logic [AnchoQ:0]  quotientIn,
  input  logic             negDivisorIn,
  input  logic             negDividendIn,
  input  logic             DivisorNoCeroIn,
  input  logic             readyIn,
  output logic             validOut,
  output logic [AnchoQ:0]  quotientOut,
  output logic [AnchoDv:0] remainderOut,
  output logic             divZeroOut,
  output logic             stallOut,
  output logic             overflowOut
);

  localparam int HiDdMin = (AnchoDd + 1) / 2;
  localparam int AnchoR  = AnchoDd + 1 - HiDdMin;

  typedef struct packed {
    logic [AnchoQ:0]  q;
    logic [AnchoDv:0] r;
    logic             dz;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  entry_t r_head;
  entry_t r_tail;
  entry_t w_new;
  logic   r_overflow;

  logic   w_push;
  logic   w_pop;
  logic   w_valid;
  logic   w_stall;

  logic [AnchoR-1:0]         w_remMag;
  logic [AnchoR+AnchoDv:0]   w_remWide;
  logic [AnchoDv:0]          w_remFit;
  logic                      w_unused;

  // Divisor and the low half of the partial remainder are carried only for debug.
  assign w_unused = ^{divisorIn, dividendIn[HiDdMin-1:0]};

  // Zero-extend first, then truncate, so any remainder/divisor width ratio works.
  assign w_remMag  = dividendIn[AnchoDd:HiDdMin];
  assign w_remWide = {{(AnchoDv+1){1'b0}}, w_remMag};
  assign w_remFit  = w_remWide[AnchoDv:0];

  always_comb begin
    w_new = '0;
    if (!DivisorNoCeroIn) begin
      w_new.q  = '1;
      w_new.r  = '0;
      w_new.dz = 1'b1;
    end else begin
      w_new.q  = (negDivisorIn ^ negDividendIn) ? (~quotientIn + 1'b1) : quotientIn;
      w_new.r  = negDividendIn ? (~w_remFit + 1'b1) : w_remFit;
      w_new.dz = 1'b0;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_valid     = (r_state != EMPTY);
    w_stall     = (r_state == FULL) && !readyIn;
    w_push      = goIn && ((r_state != FULL) || readyIn);
    w_pop       = w_valid && readyIn;
    case (r_state)
      EMPTY: begin
        if (w_push) w_stateNext = ONE;
      end
      ONE: begin
        if (w_push && !w_pop)      w_stateNext = FULL;
        else if (!w_push && w_pop) w_stateNext = EMPTY;
      end
      FULL: begin
        if (w_pop && !w_push) w_stateNext = ONE;
      end
      default: w_stateNext = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_stateNext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (goIn && w_stall) r_overflow <= 1'b1;
      case (r_state)
        EMPTY: begin
          if (w_push) r_head <= w_new;
        end
        ONE: begin
          if (w_push && w_pop) r_head <= w_new;
          else if (w_push)     r_tail <= w_new;
        end
        FULL: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (w_push) r_tail <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign validOut     = w_valid;
  assign quotientOut  = r_head.q;
  assign remainderOut = r_head.r;
  assign divZeroOut   = r_head.dz;
  assign stallOut     = w_stall;
  assign overflowOut  = r_overflow;

endmodule

// File: doc/etapa_salida.md
ETAPA_SALIDA -- requirements
Module: etapa_salida

Interface
REQ-001 The block SHALL have parameter AnchoDv, default 15, divisor MSB index.
REQ-002 The block SHALL have parameter AnchoDd, default 31, dividend MSB index.
REQ-003 The block SHALL have parameter AnchoQ, default 15, quotient MSB index.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 goIn  input  1  last divider stage holds a valid result this cycle.
REQ-008 divisorIn  input  AnchoDv+1  divisor magnitude (pass-through for debug).
REQ-009 dividendIn  input  AnchoDd+1  final partial remainder; bits [AnchoDd:HiDdMin] = remainder magnitude, HiDdMin = (AnchoDd+1)/2.
REQ-010 quotientIn  input  AnchoQ+1  quotient magnitude.
REQ-011 negDivisorIn, negDividendIn, DivisorNoCeroIn  input  1 each  operand signs; divisor non-zero flag.
REQ-012 readyIn  input  1  downstream accepts a result this cycle.
REQ-013 validOut  output  1  head result present.
REQ-014 quotientOut  output  AnchoQ+1  signed quotient of head entry.
REQ-015 remainderOut  output  AnchoDv+1  signed remainder of head entry.
REQ-016 divZeroOut  output  1  head entry was a division by zero.
REQ-017 stallOut  output  1  upstream must hold goIn low.
REQ-018 overflowOut  output  1  sticky: a result was dropped.

Function
REQ-019 Results SHALL be stored in a 2-entry in-order buffer with states EMPTY, ONE, FULL.
REQ-020 Push SHALL occur on a rising edge where goIn=1 and the buffer is not FULL, or is FULL with readyIn=1.
REQ-021 Pop SHALL occur on a rising edge where validOut=1 and readyIn=1.
REQ-022 Transitions: EMPTY-push->ONE; ONE-push-only->FULL; ONE-pop-only->EMPTY; ONE-push+pop->ONE; FULL-pop-only->ONE; FULL-push+pop->FULL; otherwise hold.
REQ-023 validOut SHALL equal 1 exactly in ONE and FULL; outputs SHALL reflect the oldest entry.
REQ-024 Latency: goIn at edge N into EMPTY SHALL give validOut=1 with that result after edge N.
REQ-025 stallOut SHALL be combinational: FULL and readyIn=0.
REQ-026 goIn=1 while stallOut=1 SHALL drop the input, leave the buffer unchanged and set overflowOut=1 until reset.
REQ-027 Quotient SHALL be two's-complement negated (mod 2^(AnchoQ+1)) when negDivisorIn XOR negDividendIn, else passed unchanged.
REQ-028 Remainder SHALL be two's-complement negated when negDividendIn=1 (sign follows dividend), else unchanged.
REQ-029 Zero magnitudes SHALL produce zero after negation.
REQ-030 DivisorNoCeroIn=0 SHALL store quotient all-ones, remainder zero, divZeroOut=1, regardless of sign flags.
REQ-031 Sign correction SHALL be computed at push time; stored entries are final values.

Reset
REQ-032 reset=1 at an edge SHALL force EMPTY, validOut=0, quotientOut=0, remainderOut=0, divZeroOut=0, overflowOut=0, discarding buffered entries.
REQ-033 reset SHALL take priority over simultaneous push/pop; goIn during reset is ignored.

Verification
REQ-034 quotientIn=14, dividendIn[31:16]=2, no negs, DivisorNoCeroIn=1, readyIn=1 -> next cycle validOut=1, quotientOut=0x000E, remainderOut=0x0002.
REQ-035 Same with negDividendIn=1 -> quotientOut=0xFFF2, remainderOut=0xFFFE; with both neg flags -> quotientOut=0x000E, remainderOut=0xFFFE.
REQ-036 DivisorNoCeroIn=0, negDividendIn=1 -> quotientOut=0xFFFF, remainderOut=0x0000, divZeroOut=1.
REQ-037 readyIn=0, goIn three consecutive cycles (q=1,2,3) -> stallOut=1 after second push, overflowOut=1, then readyIn=1 yields q=1, q=2 only, in order.
REQ-038 FULL, readyIn=1, goIn=1 (q=5) -> head pops, q=5 enters, state stays FULL, overflowOut stays 0.
REQ-039 FULL with overflowOut=1, reset pulsed one cycle -> validOut=0, overflowOut=0, stallOut=0 after edge.
